// File: rtl/uart_tx_fifo_feeder.sv
// uart_tx_fifo_feeder: byte FIFO that hands one byte at a time to a UART transmitter.
// Define TX_FIFO_OVERFLOW_EN to enable the sticky o_Overflow flag for rejected writes.
module uart_tx_fifo_feeder #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  input  logic                i_Wr_DV,
  input  logic [7:0]          i_Wr_Byte,
  output logic                o_Full,
  output logic                o_Empty,
  output logic [DEPTH_LOG2:0] o_Count,
  output logic                o_Tx_DV,
  output logic [7:0]          o_Tx_Byte,
  input  logic                i_Tx_Active,
  input  logic                i_Tx_Done,
  input  logic                i_Ovf_Clr,
  output logic                o_Overflow
);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT_ACTIVE = 2'd1, S_WAIT_DONE = 2'd2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  logic [7:0]          r_mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] r_wr_ptr, r_rd_ptr;
  logic [1:0]          r_state, w_next;
  logic                w_wr, w_pop;
  assign o_Count = r_wr_ptr - r_rd_ptr;
  assign o_Empty = r_wr_ptr == r_rd_ptr;
  assign o_Full  = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                   (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);
  assign w_wr    = i_Wr_DV && !o_Full;
  // Done stays high through the transmitter's cleanup and first idle cycle, so it gates issue too
  assign w_pop   = (r_state == S_IDLE) && !o_Empty && !i_Tx_Active && !i_Tx_Done;
  always_comb
    w_next = (r_state == S_IDLE)        ? (w_pop ? S_WAIT_ACTIVE : S_IDLE) :
             (r_state == S_WAIT_ACTIVE) ? (i_Tx_Active ? S_WAIT_DONE : S_WAIT_ACTIVE) :
                                          (i_Tx_Done ? S_IDLE : S_WAIT_DONE);
  always_ff @(posedge i_Clock)
    if (w_wr) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_Wr_Byte;
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_state   <= S_IDLE;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
    end else begin
      r_state <= w_next;
      o_Tx_DV <= w_pop;
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
        o_Tx_Byte <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
      end
    end
  end
`ifdef TX_FIFO_OVERFLOW_EN
  always_ff @(posedge i_Clock)
    if (i_Reset) o_Overflow <= 1'b0;
    else if (i_Wr_DV && o_Full) o_Overflow <= 1'b1;
    else if (i_Ovf_Clr) o_Overflow <= 1'b0;
`else
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = i_Ovf_Clr;
  assign o_Overflow = 1'b0;
`endif
endmodule
